// File: rtl/popcount_seq.sv
// Multi-cycle population counter: counts ones or zeros of one DATA_W word,
// CHUNK_W bits per cycle, with optional early exit once the remaining bits are zero.
module popcount_seq #(
  parameter int DATA_W     = 32,
  parameter int CHUNK_W    = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_mode,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(DATA_W+1)-1:0]   out_count,
  output logic                          out_parity,
  output logic                          out_full
);

  localparam int NCHUNK = DATA_W / CHUNK_W;
  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int IDX_W  = $clog2(NCHUNK + 1);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t              state, state_nx;
  logic [DATA_W-1:0]   sreg, sreg_shift;
  logic [CNT_W-1:0]    acc, acc_sum;
  logic [IDX_W-1:0]    chunk;
  logic                last_chunk;

  function automatic logic [CNT_W-1:0] chunk_pop(input logic [CHUNK_W-1:0] bits);
    logic [CNT_W-1:0] s;
    s = '0;
    for (int i = 0; i < CHUNK_W; i++) s = s + CNT_W'(bits[i]);
    return s;
  endfunction

  // A single-chunk word has nothing left after the first shift.
  generate
    if (NCHUNK == 1) begin : g_single
      assign sreg_shift = '0;
    end else begin : g_multi
      assign sreg_shift = {{CHUNK_W{1'b0}}, sreg[DATA_W-1:CHUNK_W]};
    end
  endgenerate

  assign acc_sum    = acc + chunk_pop(sreg[CHUNK_W-1:0]);
  assign last_chunk = (chunk == IDX_W'(NCHUNK - 1)) ||
                      ((EARLY_EXIT != 0) && (sreg_shift == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = COUNT;
      end
      COUNT:   if (last_chunk) state_nx = DONE;
      DONE:    if (out_ready)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg       <= '0;
      acc        <= '0;
      chunk      <= '0;
      out_valid  <= 1'b0;
      out_count  <= '0;
      out_parity <= 1'b0;
      out_full   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sreg  <= in_mode ? ~in_data : in_data;
            acc   <= '0;
            chunk <= '0;
          end
        end
        COUNT: begin
          acc   <= acc_sum;
          sreg  <= sreg_shift;
          chunk <= chunk + 1'b1;
          if (last_chunk) begin
            out_count  <= acc_sum;
            out_parity <= acc_sum[0];
            out_full   <= (acc_sum == CNT_W'(DATA_W));
            out_valid  <= 1'b1;
          end
        end
        DONE:    if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_seq.sv
// Bench for popcount_seq: three shared-stimulus instances (fixed latency, early exit,
// single-chunk) compared against a word-level count/latency model.
module tb_popcount_seq;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_mode, out_ready;
  logic [31:0]       in_data;
  logic [2:0]        ir, ov, op, of;
  logic [2:0][5:0]   oc;

  int                lat  [3];
  logic [5:0]        cnt  [3];
  logic              par  [3];
  logic              full [3];
  int                checks, errors;

  always #5 clk = ~clk;

  popcount_seq #(.DATA_W(32), .CHUNK_W(8), .EARLY_EXIT(0)) u_fixed (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .in_mode(in_mode), .out_valid(ov[0]), .out_ready(out_ready),
    .out_count(oc[0]), .out_parity(op[0]), .out_full(of[0]));

  popcount_seq #(.DATA_W(32), .CHUNK_W(8), .EARLY_EXIT(1)) u_early (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data), .in_mode(in_mode), .out_valid(ov[1]), .out_ready(out_ready),
    .out_count(oc[1]), .out_parity(op[1]), .out_full(of[1]));

  popcount_seq #(.DATA_W(32), .CHUNK_W(32), .EARLY_EXIT(0)) u_wide (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
    .in_data(in_data), .in_mode(in_mode), .out_valid(ov[2]), .out_ready(out_ready),
    .out_count(oc[2]), .out_parity(op[2]), .out_full(of[2]));

  // Reference model: counted bits of the whole word, and cycles to result per instance.
  function automatic int model_count(input logic [31:0] w, input logic m);
    return m ? (32 - $countones(w)) : $countones(w);
  endfunction

  function automatic int model_lat(input int inst, input logic [31:0] w, input logic m);
    logic [31:0] cw;
    int hi;
    cw = m ? ~w : w;
    if (inst == 0) return 4;
    if (inst == 2) return 1;
    if (cw == 0) return 1;
    hi = 0;
    for (int b = 0; b < 32; b++) if (cw[b]) hi = b;
    return 1 + hi / 8;
  endfunction

  task automatic drive_accept(input logic [31:0] w, input logic m);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    in_mode  = m;
    @(posedge clk);
  endtask

  // Waits for every instance to raise out_valid, recording latency and result at the rise.
  task automatic collect();
    logic [2:0] got;
    got = '0;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
    in_mode  = 1'($urandom);
    for (int k = 1; k <= 20 && got != 3'b111; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        if (ov[i] && !got[i]) begin
          got[i]  = 1'b1;
          lat[i]  = k;
          cnt[i]  = oc[i];
          par[i]  = op[i];
          full[i] = of[i];
        end
      end
    end
    if (got != 3'b111) begin
      checks++; errors++;
      $display("FAIL collect_timeout out_valid_seen=%b required=111", got);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ov !== 3'b000 || ir !== 3'b111) begin
      errors++;
      $display("FAIL reset_hold out_valid=%b in_ready=%b required 000/111", ov, ir);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ir !== 3'b111 || ov !== 3'b000 || oc !== '0 || of !== 3'b000 || op !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle in_ready=%b out_valid=%b out_count=%h required 111/000/0", ir, ov, oc);
    end
  endtask

  task automatic test_directed(input logic [31:0] w, input logic m, input string name);
    int ec;
    ec = model_count(w, m);
    drive_accept(w, m);
    collect();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (lat[i] !== model_lat(i, w, m) || cnt[i] !== 6'(ec) || par[i] !== 1'(ec % 2) ||
          full[i] !== (ec == 32)) begin
        errors++;
        $display("FAIL %s inst%0d lat=%0d cnt=%0d par=%b full=%b required lat=%0d cnt=%0d par=%0d full=%0d",
                 name, i, lat[i], cnt[i], par[i], full[i], model_lat(i, w, m), ec, ec % 2, ec == 32);
      end
    end
    checks++;
    if (ir !== 3'b111 || ov !== 3'b000) begin
      errors++;
      $display("FAIL %s_return_idle in_ready=%b out_valid=%b required 111/000", name, ir, ov);
    end
  endtask

  task automatic test_fixed_patterns();
    test_directed(32'hF0F0_0001, 1'b0, "mode0_f0f00001");
    test_directed(32'h1234_5678, 1'b0, "mode0_next_word");
    test_directed(32'h0000_0000, 1'b1, "mode1_all_zero");
    test_directed(32'hFFFF_FFFF, 1'b0, "mode0_all_one");
  endtask

  task automatic test_early_exit();
    test_directed(32'h0000_0003, 1'b0, "early_0003");
    test_directed(32'h0100_0000, 1'b0, "early_01000000");
    test_directed(32'h0000_0000, 1'b0, "early_zero");
    test_directed(32'hFFFF_00FF, 1'b1, "early_mode1_chunk1");
  endtask

  task automatic test_random();
    logic [31:0] w;
    logic        m;
    for (int n = 0; n < 40; n++) begin
      w = $urandom;
      case ($urandom_range(0, 3))
        0: ;
        1: w = w & (32'h0000_00FF << (8 * $urandom_range(0, 3)));
        2: w = w >> $urandom_range(0, 31);
        default: w = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h0;
      endcase
      m = 1'($urandom);
      test_directed(w, m, "random");
    end
  endtask

  task automatic test_back_to_back_backpressure();
    logic [31:0]     w1, w2;
    logic            m1, m2;
    logic [2:0][5:0] snap_oc;
    logic [2:0]      snap_op, snap_of;
    int              e1, e2;
    w1 = $urandom; m1 = 1'($urandom); e1 = model_count(w1, m1);
    w2 = $urandom; m2 = 1'($urandom); e2 = model_count(w2, m2);
    @(negedge clk);
    out_ready = 1'b0;
    drive_accept(w1, m1);
    collect();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cnt[i] !== 6'(e1) || lat[i] !== model_lat(i, w1, m1)) begin
        errors++;
        $display("FAIL bp_first inst%0d cnt=%0d lat=%0d required cnt=%0d lat=%0d",
                 i, cnt[i], lat[i], e1, model_lat(i, w1, m1));
      end
    end
    snap_oc = oc; snap_op = op; snap_of = of;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w2;
    in_mode  = m2;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if (ov !== 3'b111 || ir !== 3'b000 || oc !== snap_oc || op !== snap_op || of !== snap_of) begin
        errors++;
        $display("FAIL bp_hold cycle%0d out_valid=%b in_ready=%b out_count=%h required 111/000/%h",
                 c, ov, ir, oc, snap_oc);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ov !== 3'b000 || ir !== 3'b111 || oc !== snap_oc) begin
      errors++;
      $display("FAIL bp_release out_valid=%b in_ready=%b out_count=%h required 000/111/%h",
               ov, ir, oc, snap_oc);
    end
    @(posedge clk);
    collect();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cnt[i] !== 6'(e2) || lat[i] !== model_lat(i, w2, m2)) begin
        errors++;
        $display("FAIL bp_second inst%0d cnt=%0d lat=%0d required cnt=%0d lat=%0d",
                 i, cnt[i], lat[i], e2, model_lat(i, w2, m2));
      end
    end
  endtask

  task automatic test_reset_mid_count();
    drive_accept(32'hFF00_00FF, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ov !== 3'b000 || oc !== '0 || of !== 3'b000 || op !== 3'b000 || ir !== 3'b111) begin
      errors++;
      $display("FAIL reset_mid_async out_valid=%b out_count=%h out_full=%b in_ready=%b required 000/0/000/111",
               ov, oc, of, ir);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      checks++;
      if (ov !== 3'b000 || ir !== 3'b111) begin
        errors++;
        $display("FAIL reset_mid_stale cycle%0d out_valid=%b in_ready=%b required 000/111", c, ov, ir);
      end
    end
    test_directed(32'h8000_0001, 1'b0, "after_reset");
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_fixed_patterns();
    test_early_exit();
    test_random();
    test_back_to_back_backpressure();
    test_reset_mid_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
